// File: rtl/hazard_ctrl.sv
// hazard_ctrl: in-order pipeline hazard controller (RAW scoreboard, redirect flush, memory freeze with watchdog, SYSTEM drain/halt)
//   clk, rst                : core clock, asynchronous active-low reset
//   id_*_i                  : instruction in ID (valid, sources, destination, SYSTEM flag)
//   ex_redirect_i           : taken branch/jump resolved in EX
//   mem_req_i, mem_ready_i  : data-memory request and completion
//   wb_*_i                  : instruction retiring in WB
//   stall_if_o, stall_id_o, flush_id_o, bubble_ex_o, freeze_o, issue_o : pipeline control
//   halted_o, mem_err_o     : core halted, sticky memory timeout
module hazard_ctrl #(
    parameter int NREGS       = 32,
    parameter int CNT_W       = 2,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid_i,
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       id_rs1_used_i,
    input  logic       id_rs2_used_i,
    input  logic [4:0] id_rd_i,
    input  logic       id_rf_wr_en_i,
    input  logic       id_is_system_i,
    input  logic       ex_redirect_i,
    input  logic       mem_req_i,
    input  logic       mem_ready_i,
    input  logic       wb_valid_i,
    input  logic       wb_rf_wr_en_i,
    input  logic [4:0] wb_rd_i,
    output logic       stall_if_o,
    output logic       stall_id_o,
    output logic       flush_id_o,
    output logic       bubble_ex_o,
    output logic       freeze_o,
    output logic       issue_o,
    output logic       halted_o,
    output logic       mem_err_o
);
    localparam int WD_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {RUN, FLUSH, DRAIN, HALTED} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q [NREGS];
    logic [CNT_W-1:0] cnt_d [NREGS];
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             mem_err_q, mem_err_d;
    logic [NREGS-1:0] up, dn, live;
    logic             halted, retire, inc, haz_rs1, haz_rs2, drain_done, timeout;

    // Outputs are forced to zero while reset is held so they clear without a clock.
    assign halted     = state_q == HALTED;
    assign freeze_o   = rst & ~halted & mem_req_i & ~mem_ready_i;
    assign retire     = wb_valid_i & wb_rf_wr_en_i & (wb_rd_i != '0) & ~freeze_o;
    assign inc        = issue_o & id_rf_wr_en_i & (id_rd_i != '0);
    assign drain_done = ~|live;
    // A retiring write to the source register resolves the hazard in the same cycle (regfile write-through).
    assign haz_rs1    = id_rs1_used_i & (id_rs1_i != '0) & live[id_rs1_i];
    assign haz_rs2    = id_rs2_used_i & (id_rs2_i != '0) & live[id_rs2_i];
    assign timeout    = freeze_o & (wd_q == WD_W'(MEM_TIMEOUT - 1));
    assign wd_d       = freeze_o ? wd_q + WD_W'(1) : '0;
    assign mem_err_d  = mem_err_q | timeout;
    assign mem_err_o  = mem_err_q;

    for (genvar g = 0; g < NREGS; g++) begin : g_reg
        assign up[g]    = inc & (id_rd_i == 5'(g));
        assign dn[g]    = retire & (wb_rd_i == 5'(g));
        assign live[g]  = (cnt_q[g] - CNT_W'(dn[g])) != '0;
        assign cnt_d[g] = (up[g] == dn[g]) ? cnt_q[g] :
                          up[g] ? ((cnt_q[g] == CNT_MAX) ? cnt_q[g] : cnt_q[g] + CNT_W'(1)) :
                                  ((cnt_q[g] == '0) ? cnt_q[g] : cnt_q[g] - CNT_W'(1));
        assert property (@(posedge clk) disable iff (!rst) !(up[g] && !dn[g] && cnt_q[g] == CNT_MAX));
        assert property (@(posedge clk) disable iff (!rst) !(dn[g] && !up[g] && cnt_q[g] == '0));
    end

    // Priority: freeze > redirect > FSM state > RAW hazard; a freeze holds the FSM in place.
    always_comb begin
        state_d     = state_q;
        stall_if_o  = 1'b0;
        stall_id_o  = 1'b0;
        flush_id_o  = 1'b0;
        bubble_ex_o = 1'b0;
        issue_o     = 1'b0;
        halted_o    = 1'b0;
        if (!rst) begin
            state_d = RUN;
        end else if (halted) begin
            halted_o    = 1'b1;
            stall_if_o  = 1'b1;
            stall_id_o  = 1'b1;
            bubble_ex_o = 1'b1;
        end else if (freeze_o) begin
            state_d = state_q;
        end else if (ex_redirect_i) begin
            flush_id_o  = 1'b1;
            bubble_ex_o = 1'b1;
            state_d     = FLUSH;
        end else if (state_q == FLUSH) begin
            flush_id_o  = 1'b1;
            bubble_ex_o = 1'b1;
            state_d     = RUN;
        end else if (state_q == DRAIN) begin
            stall_if_o  = 1'b1;
            stall_id_o  = 1'b1;
            bubble_ex_o = 1'b1;
            state_d     = (drain_done & ~mem_req_i) ? HALTED : DRAIN;
        end else if (id_valid_i & id_is_system_i) begin
            stall_if_o  = 1'b1;
            stall_id_o  = 1'b1;
            bubble_ex_o = 1'b1;
            state_d     = DRAIN;
        end else if (haz_rs1 | haz_rs2) begin
            stall_if_o  = 1'b1;
            stall_id_o  = 1'b1;
            bubble_ex_o = 1'b1;
        end else begin
            issue_o = id_valid_i;
        end
        if (timeout) state_d = HALTED;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= RUN;
            wd_q      <= '0;
            mem_err_q <= 1'b0;
            cnt_q     <= '{default: '0};
        end else begin
            state_q   <= state_d;
            wd_q      <= wd_d;
            mem_err_q <= mem_err_d;
            cnt_q     <= cnt_d;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl against an in-order queue reference model
module tb_hazard_ctrl;
    localparam int TO = 64;
    localparam int M_RUN = 0, M_FLUSH = 1, M_DRAIN = 2, M_HALT = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic id_valid, rs1_used, rs2_used, rf_wr, is_sys, ex_redir, mem_req, mem_ready, wb_valid, wb_wr;
    logic [4:0] rs1, rs2, rd, wb_rd;
    logic stall_if, stall_id, flush_id, bubble_ex, freeze, issue, halted, mem_err;

    hazard_ctrl #(.NREGS(32), .CNT_W(2), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .id_valid_i(id_valid), .id_rs1_i(rs1), .id_rs2_i(rs2),
        .id_rs1_used_i(rs1_used), .id_rs2_used_i(rs2_used), .id_rd_i(rd),
        .id_rf_wr_en_i(rf_wr), .id_is_system_i(is_sys), .ex_redirect_i(ex_redir),
        .mem_req_i(mem_req), .mem_ready_i(mem_ready),
        .wb_valid_i(wb_valid), .wb_rf_wr_en_i(wb_wr), .wb_rd_i(wb_rd),
        .stall_if_o(stall_if), .stall_id_o(stall_id), .flush_id_o(flush_id),
        .bubble_ex_o(bubble_ex), .freeze_o(freeze), .issue_o(issue),
        .halted_o(halted), .mem_err_o(mem_err)
    );

    always #5 clk = ~clk;

    int mode = M_RUN;
    int fz = 0;
    int busy_left = 0;
    bit merr = 1'b0;
    int inflight[$];
    logic [7:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    string names[8] = '{"mem_err_o", "halted_o", "issue_o", "freeze_o",
                        "bubble_ex_o", "flush_id_o", "stall_id_o", "stall_if_o"};

    // Pending writes to r among in-flight instructions, ignoring the first `skip` (oldest) entries.
    function automatic int count_in(input int r, input int skip);
        int c = 0;
        for (int i = skip; i < inflight.size(); i++) if (inflight[i] == r) c++;
        return c;
    endfunction

    task automatic idle();
        id_valid = 0; rs1 = 0; rs2 = 0; rs1_used = 0; rs2_used = 0; rd = 0; rf_wr = 0;
        is_sys = 0; ex_redir = 0; mem_req = 0; mem_ready = 0; wb_valid = 0; wb_wr = 0; wb_rd = 0;
    endtask

    // Expected bits: {stall_if, stall_id, flush, bubble, freeze, issue, halted, mem_err}
    task automatic model_step();
        logic [7:0] e;
        bit frozen, ret, haz;
        int nxt, skip;
        e = '0;
        if (!rst) begin
            mode = M_RUN; fz = 0; merr = 0; inflight.delete();
            exp_q.push_back(e);
            return;
        end
        frozen = mode != M_HALT && mem_req && !mem_ready;
        ret = wb_valid && wb_wr && wb_rd != 0 && !frozen && inflight.size() > 0;
        skip = ret ? 1 : 0;
        haz = (rs1_used && rs1 != 0 && count_in(int'(rs1), skip) > 0) ||
              (rs2_used && rs2 != 0 && count_in(int'(rs2), skip) > 0);
        nxt = mode;
        if (mode == M_HALT) e = 8'b1101_0010;
        else if (frozen) e[3] = 1;
        else if (ex_redir) begin e[5] = 1; e[4] = 1; nxt = M_FLUSH; end
        else if (mode == M_FLUSH) begin e[5] = 1; e[4] = 1; nxt = M_RUN; end
        else if (mode == M_DRAIN) begin
            e[7:6] = 2'b11; e[4] = 1;
            if (inflight.size() == skip && !mem_req) nxt = M_HALT;
        end
        else if (id_valid && is_sys) begin e[7:6] = 2'b11; e[4] = 1; nxt = M_DRAIN; end
        else if (haz) begin e[7:6] = 2'b11; e[4] = 1; end
        else e[2] = id_valid;
        e[0] = merr;
        exp_q.push_back(e);
        if (ret) inflight.delete(0);
        if (e[2] && rf_wr && rd != 0) inflight.push_back(int'(rd));
        mode = nxt;
        if (frozen) begin
            fz++;
            if (fz >= TO) begin merr = 1; mode = M_HALT; end
        end else fz = 0;
    endtask

    task automatic drive_random();
        int k;
        if (busy_left > 0) begin mem_req = 1; mem_ready = (busy_left == 1); busy_left--; end
        else if ($urandom_range(9) == 0) begin busy_left = $urandom_range(6, 1); mem_req = 1; mem_ready = 0; end
        else begin mem_req = ($urandom_range(3) == 0); mem_ready = mem_req; end
        ex_redir = ($urandom_range(11) == 0);
        id_valid = ($urandom_range(4) != 0);
        rs1 = 5'($urandom_range(7)); rs2 = 5'($urandom_range(7));
        rs1_used = $urandom_range(1) != 0; rs2_used = $urandom_range(1) != 0;
        is_sys = ($urandom_range(79) == 0);
        rd = 5'($urandom_range(7, 1));
        rf_wr = ($urandom_range(3) != 0) && count_in(int'(rd), 0) < 3;
        k = $urandom_range(9);
        if (inflight.size() > 0 && k < 4) begin wb_valid = 1; wb_wr = 1; wb_rd = 5'(inflight[0]); end
        else if (inflight.size() > 0 && k == 4) begin wb_valid = 0; wb_wr = 1; wb_rd = 5'(inflight[0]); end
        else begin wb_valid = $urandom_range(1) != 0; wb_wr = 0; wb_rd = 5'($urandom_range(31)); end
    endtask

    task automatic apply(input bit v, input int r1, input bit u1, input int r2, input bit u2,
                         input int d, input bit we, input bit sys, input bit redir,
                         input bit mreq, input bit mrdy, input bit wv, input int wrd);
        @(posedge clk); #1;
        id_valid = v; rs1 = 5'(r1); rs1_used = u1; rs2 = 5'(r2); rs2_used = u2;
        rd = 5'(d); rf_wr = we; is_sys = sys; ex_redir = redir;
        mem_req = mreq; mem_ready = mrdy; wb_valid = wv; wb_wr = wv; wb_rd = 5'(wrd);
        model_step();
    endtask

    // Reset is dropped between clock edges with the previous (possibly busy) inputs still applied.
    task automatic do_reset();
        @(posedge clk); #1;
        rst = 0;
        model_step();
        repeat (2) begin @(posedge clk); #1; idle(); model_step(); end
        @(posedge clk); #1;
        rst = 1; idle(); busy_left = 0;
        model_step();
    endtask

    initial begin
        logic [7:0] act, e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                act = {stall_if, stall_id, flush_id, bubble_ex, freeze, issue, halted, mem_err};
                for (int i = 0; i < 8; i++) begin
                    n_cmp++;
                    if (act[i] !== e[i]) begin
                        n_bad++;
                        $display("FAIL %s at %0t: got %b expected %b", names[i], $time, act[i], e[i]);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        do_reset();
        // RAW hazard on x5, write-through release, x0 and unused sources
        apply(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0);
        repeat (3) apply(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 0, 0, 0);
        apply(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 0, 1, 5);
        apply(1, 0, 1, 6, 0, 7, 0, 0, 0, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6);
        // Redirect, then redirect held off by a freeze
        apply(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        repeat (2) apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) apply(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        apply(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0);
        repeat (2) apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Freeze for 5 cycles keeps x9 in flight even with WB presenting it
        apply(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0);
        repeat (5) apply(1, 9, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 9);
        apply(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        apply(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9);
        // SYSTEM drain with two writes in flight, then asynchronous reset while halted
        apply(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0);
        apply(1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0);
        apply(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4);
        repeat (2) apply(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        do_reset();
        // Memory timeout
        repeat (70) apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        do_reset();
        // Randomized episodes
        repeat (6) begin
            repeat (300) begin @(posedge clk); #1; drive_random(); model_step(); end
            do_reset();
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
